// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: round-robin arbiter that multiplexes CH_NUM user channels onto a
// single UDP transmitter. It rejects bad lengths and aborts a transfer that stalls.
module udp_tx_arbiter #(
    parameter int          CH_NUM  = 4,
    parameter logic [15:0] MAX_LEN = 16'd1472,
    parameter int          TIMEOUT = 1024
) (
    input  logic                      gmii_tx_clk,
    input  logic                      rst,
    input  logic [CH_NUM-1:0]         ch_tx_en,
    input  logic [CH_NUM*16-1:0]      ch_tx_data_num,
    input  logic [CH_NUM*8-1:0]       ch_tx_data,
    output logic [CH_NUM-1:0]         ch_tx_req,
    output logic [CH_NUM-1:0]         ch_tx_ack,
    output logic [CH_NUM-1:0]         ch_tx_done,
    output logic [CH_NUM-1:0]         ch_tx_err,
    output logic                      udp_tx_en,
    output logic [15:0]               udp_tx_data_num,
    output logic [7:0]                udp_tx_data,
    input  logic                      udp_tx_req,
    input  logic                      tx_rdy,
    output logic                      busy,
    output logic [$clog2(CH_NUM)-1:0] cur_ch
);

    localparam int CH_W = $clog2(CH_NUM);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, XFER, WAIT_END} state_e;

    state_e          state_q, state_d;
    logic [CH_W-1:0] last_grant_q, last_grant_d;
    logic [CH_W-1:0] cur_ch_q, cur_ch_d;
    logic [15:0]     len_q, len_d;
    logic [15:0]     byte_cnt_q, byte_cnt_d;
    logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;

    logic            grant_found;
    logic [CH_W-1:0] grant_idx;
    logic [15:0]     grant_len;

    // Search starts one past the last winner so every requester is served in turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_grant_q;
        for (int k = 1; k <= CH_NUM; k++) begin
            if (!grant_found && ch_tx_en[(int'(last_grant_q) + k) % CH_NUM]) begin
                grant_found = 1'b1;
                grant_idx   = CH_W'((int'(last_grant_q) + k) % CH_NUM);
            end
        end
        grant_len = ch_tx_data_num[16*int'(grant_idx) +: 16];
    end

    always_comb begin
        // NOTE: every _d and every output is defaulted first, so no path can infer a latch.
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        cur_ch_d        = cur_ch_q;
        len_d           = len_q;
        byte_cnt_d      = byte_cnt_q;
        idle_cnt_d      = idle_cnt_q;
        ch_tx_req       = '0;
        ch_tx_ack       = '0;
        ch_tx_done      = '0;
        ch_tx_err       = '0;
        udp_tx_en       = 1'b0;
        udp_tx_data_num = '0;
        udp_tx_data     = '0;
        busy            = 1'b0;
        cur_ch          = '0;

        // Outputs are held at zero for the whole reset cycle, not just after it.
        if (!rst) begin
            busy   = (state_q != IDLE);
            cur_ch = cur_ch_q;
            if (state_q != IDLE) begin
                udp_tx_data_num = len_q;
                udp_tx_data     = ch_tx_data[8*int'(cur_ch_q) +: 8];
            end

            unique case (state_q)
                IDLE: begin
                    if (tx_rdy && grant_found) begin
                        last_grant_d = grant_idx;
                        cur_ch_d     = grant_idx;
                        len_d        = grant_len;
                        byte_cnt_d   = '0;
                        idle_cnt_d   = '0;
                        if (grant_len == 16'd0 || grant_len > MAX_LEN) begin
                            ch_tx_err[grant_idx] = 1'b1;
                        end else begin
                            ch_tx_ack[grant_idx] = 1'b1;
                            state_d              = START;
                        end
                    end
                end
                START: begin
                    udp_tx_en = 1'b1;
                    state_d   = XFER;
                end
                XFER: begin
                    if (udp_tx_req) begin
                        ch_tx_req[cur_ch_q] = 1'b1;
                        byte_cnt_d          = byte_cnt_q + 16'd1;
                        idle_cnt_d          = '0;
                        if (byte_cnt_q + 16'd1 == len_q) state_d = WAIT_END;
                    end else if (idle_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        ch_tx_err[cur_ch_q] = 1'b1;
                        state_d             = IDLE;
                    end else begin
                        idle_cnt_d = idle_cnt_q + TO_W'(1);
                    end
                end
                WAIT_END: begin
                    if (tx_rdy) begin
                        ch_tx_done[cur_ch_q] = 1'b1;
                        state_d              = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge gmii_tx_clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= CH_W'(CH_NUM - 1);
            cur_ch_q     <= '0;
            len_q        <= '0;
            byte_cnt_q   <= '0;
            idle_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cur_ch_q     <= cur_ch_d;
            len_q        <= len_d;
            byte_cnt_q   <= byte_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
        end
    end

endmodule

// File: doc/udp_tx_arbiter.md
UDP_TX_ARBITER -- requirements
Module: udp_tx_arbiter

Interface
REQ-001 SHALL have parameter CH_NUM, default 4, number of user UDP channels (2..8).
REQ-002 SHALL have parameter MAX_LEN, default 16'd1472, maximum UDP payload bytes per frame.
REQ-003 SHALL have parameter TIMEOUT, default 1024, cycles without udp_tx_req before a frame is aborted.
REQ-004 SHALL have one clock and a synchronous, active-high reset; ports named gmii_tx_clk and rst.
REQ-005 SHALL have ports:
  gmii_tx_clk  in  1  GMII transmit clock; all logic on its rising edge
  rst  in  1  synchronous reset, active-high
  ch_tx_en  in  CH_NUM  per-channel send request, level, held until ack or err
  ch_tx_data_num  in  CH_NUM*16  per-channel payload length, channel i at [16i+15:16i]
  ch_tx_data  in  CH_NUM*8  per-channel payload byte, valid one cycle after ch_tx_req
  ch_tx_req  out  CH_NUM  per-channel byte request
  ch_tx_ack  out  CH_NUM  one-cycle grant pulse
  ch_tx_done  out  CH_NUM  one-cycle frame-complete pulse
  ch_tx_err  out  CH_NUM  one-cycle reject/abort pulse
  udp_tx_en  out  1  one-cycle start pulse to UDP transmitter
  udp_tx_data_num  out  16  latched length, stable from udp_tx_en until IDLE
  udp_tx_data  out  8  byte from granted channel
  udp_tx_req  in  1  byte request from UDP transmitter
  tx_rdy  in  1  transmitter idle; low from cycle after udp_tx_en until frame end
  busy  out  1  high in any state except IDLE
  cur_ch  out  $clog2(CH_NUM)  granted channel index

Function
REQ-006 SHALL implement FSM states IDLE, START, XFER, WAIT_END.
REQ-007 IDLE: when tx_rdy=1 and any ch_tx_en=1, grant by round-robin searching from last_grant+1 upward with wrap; latch length and index in same cycle.
REQ-008 Latched length 0 or >MAX_LEN: pulse ch_tx_err[g], update last_grant, remain IDLE; no udp_tx_en.
REQ-009 Valid length: pulse ch_tx_ack[g], update last_grant, go START.
REQ-010 START: assert udp_tx_en for exactly one cycle, udp_tx_data_num=latched length; go XFER; grant-to-udp_tx_en latency 1 cycle.
REQ-011 XFER: ch_tx_req[g]=udp_tx_req combinationally; ch_tx_req of other channels 0.
REQ-012 udp_tx_data SHALL be ch_tx_data of granted channel (combinational mux); 8'd0 in IDLE.
REQ-013 16-bit byte counter increments per udp_tx_req in XFER; on the request making count equal length, go WAIT_END.
REQ-014 udp_tx_req beyond length (WAIT_END) SHALL be ignored: no ch_tx_req, counter frozen.
REQ-015 XFER idle counter resets on each udp_tx_req; reaching TIMEOUT: pulse ch_tx_err[g], go IDLE.
REQ-016 WAIT_END: on tx_rdy=1 pulse ch_tx_done[g], go IDLE; next grant no earlier than the following cycle.
REQ-017 ch_tx_en deassertion or ch_tx_data_num change after grant SHALL NOT affect the current frame.
REQ-018 Multiple simultaneous ch_tx_en: exactly one granted per arbitration; never two ack/err bits in one cycle.
REQ-019 Single active channel SHALL be regranted repeatedly without waiting for others.
REQ-020 busy=1 in START, XFER, WAIT_END; cur_ch holds granted index until next grant.

Reset
REQ-021 rst=1 SHALL force IDLE, counters 0, last_grant=CH_NUM-1 (channel 0 has first priority), all outputs 0.
REQ-022 rst mid-frame SHALL abort with no done/err pulse; udp_tx_en not reissued.

Verification
REQ-023 ch0 len 4, tx_rdy=1 -> ack[0] cycle T, udp_tx_en T+1 with num=4, 4 bytes forwarded, done[0] when tx_rdy returns high.
REQ-024 ch0..ch3 all requesting from reset -> grant order 0,1,2,3,0; one ack per frame.
REQ-025 ch2 len 0, then len 1473 -> err[2] each time, no udp_tx_en, busy stays 0.
REQ-026 granted frame len 3, transmitter issues 5 requests -> ch_tx_req pulses exactly 3.
REQ-027 TIMEOUT=16, no udp_tx_req after START -> err[g] at cycle 16 of XFER, busy falls next cycle.
REQ-028 rst during XFER byte 2 of 10 -> all outputs 0 next cycle; subsequent ch1+ch3 requests grant ch1 first.
